// File: rtl/forloop_counter_bank.sv
// Bank of NCH independent WIDTH-bit up-counters with per-channel enable,
// clear and load, wrap/saturate mode, overflow pulses, sticky terminal-count
// flags and a registered readout mux.

// One counter channel: clr > ld > en > hold.
module forloop_counter_lane #(
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0
) (
  input  logic             c,
  input  logic             r,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             tc_clr,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] nxt;
  logic             ovf_nxt;
  logic             tc_set;

  // Next count, overflow pulse and terminal-count set condition.
  always_comb begin
    nxt     = cnt;
    ovf_nxt = 1'b0;
    tc_set  = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (ld) begin
      nxt    = ld_val;
      tc_set = (ld_val == MAX);
    end else if (en) begin
      if (cnt == MAX) begin
        ovf_nxt = 1'b1;
        nxt     = (SATURATE != 0) ? MAX : '0;
        tc_set  = (SATURATE != 0);
      end else begin
        nxt    = cnt + 1'b1;
        tc_set = (nxt == MAX);
      end
    end
  end

  // State update; a set on the same edge as tc_clr keeps the flag.
  always_ff @(posedge c or posedge r) begin
    if (r) begin
      cnt <= '0;
      ovf <= 1'b0;
      tc  <= 1'b0;
    end else begin
      cnt <= nxt;
      ovf <= ovf_nxt;
      tc  <= tc_set | (tc & ~tc_clr);
    end
  end
endmodule

module forloop_counter_bank #(
  parameter int NCH      = 4,
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  localparam int SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               c,
  input  logic               r,
  input  logic [NCH-1:0]     en,
  input  logic [NCH-1:0]     clr,
  input  logic [NCH-1:0]     ld,
  input  logic [WIDTH-1:0]   ld_val,
  input  logic               tc_clr,
  input  logic [SELW-1:0]    sel,
  output logic [NCH*WIDTH-1:0] cnt,
  output logic [WIDTH-1:0]   rd_val,
  output logic [NCH-1:0]     tc,
  output logic [NCH-1:0]     ovf
);
  logic [NCH-1:0][WIDTH-1:0] cnt_a;
  logic [WIDTH-1:0]          rd_nxt;

  for (genvar j = 0; j < NCH; j++) begin : g_ch
    forloop_counter_lane #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_lane (
      .c      (c),
      .r      (r),
      .en     (en[j]),
      .clr    (clr[j]),
      .ld     (ld[j]),
      .ld_val (ld_val),
      .tc_clr (tc_clr),
      .cnt    (cnt_a[j]),
      .tc     (tc[j]),
      .ovf    (ovf[j])
    );
  end

  // Packed channel array lays out channel j at [j*WIDTH +: WIDTH].
  assign cnt = cnt_a;

  // Readout select; out-of-range select reads as zero.
  always_comb begin
    rd_nxt = '0;
    for (int j = 0; j < NCH; j++)
      if (sel == SELW'(j)) rd_nxt = cnt_a[j];
  end

  // Register the pre-update value of the selected channel.
  always_ff @(posedge c or posedge r) begin
    if (r) rd_val <= '0;
    else   rd_val <= rd_nxt;
  end
endmodule
